// File: rtl/mem_initiator_pkg.sv
// mem_initiator_pkg: shared types and constants for the data-memory initiator.
//   - state_e          : initiator FSM states (verify states used only when
//                        MEM_INITIATOR_WRITE_VERIFY_EN is defined)
//   - OP_READ/OP_WRITE : encoding of req_write
//   - LEN_W            : width of the burst length field (beats minus one)
//   - MEM_ADDR_W/MEM_DATA_W : geometry of the 32x8 asynchronous data memory
package mem_initiator_pkg;

    localparam int unsigned LEN_W      = 3;
    localparam int unsigned MEM_ADDR_W = 5;
    localparam int unsigned MEM_DATA_W = 8;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [3:0] {
        StIdle,
        StWdata,
        StSetup,
        StStrobe,
        StHold,
        StSample,
        StRvalid,
        StDone,
        StVsetup,
        StVsample
    } state_e;

endpackage

// File: rtl/mem_addr_gen.sv
// mem_addr_gen: current burst address and remaining-beat counter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture start_addr / len (burst start)
//   step        : advance to the next beat (addr+1 modulo depth, count-1)
//   start_addr  : first address of the burst
//   len         : beats minus one
//   addr        : current beat address
//   last        : current beat is the final one of the burst
module mem_addr_gen
    import mem_initiator_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [LEN_W-1:0] count;

    // Address arithmetic is ADDR_W bits wide, so the increment wraps at 2**ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= '0;
            count <= '0;
        end else if (load) begin
            addr  <= start_addr;
            count <= len;
        end else if (step) begin
            addr  <= addr + 1'b1;
            count <= count - 1'b1;
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/mem_initiator.sv
// mem_initiator: burst initiator for the 32x8 level-sensitive asynchronous data memory.
// Accepts read/write bursts on a valid/ready request channel, takes write beats on the
// w_* channel, returns read beats on the r_* channel with backpressure, and sequences
// setup / strobe / hold so mem_write is never high while mem_address changes.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   req_valid/req_ready             : request handshake (ready only when idle)
//   req_write, req_addr, req_len    : operation, start address, beats minus one
//   w_valid/w_ready, w_data         : write beat channel
//   r_valid/r_ready, r_data, r_last : read beat channel
//   done                            : one-cycle pulse when a burst completes
//   mem_address, mem_data_in,
//   mem_write, mem_data_out         : memory interface
//   verify_err                      : sticky read-after-write mismatch flag
//                                     (only with MEM_INITIATOR_WRITE_VERIFY_EN)
// Build option: define MEM_INITIATOR_WRITE_VERIFY_EN to read back and compare every
// written word after its hold cycle.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int unsigned ADDR_W    = MEM_ADDR_W,
    parameter int unsigned DATA_W    = MEM_DATA_W,
    parameter int unsigned SETUP_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DATA_W-1:0] w_data,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [DATA_W-1:0] r_data,
    output logic              r_last,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write,
`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
    output logic              verify_err,
`endif
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [2:0] SETUP_LAST = 3'(SETUP_CYC - 1);

    // State in which a write beat is finished and the burst either ends or continues.
`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
    localparam state_e WBEAT_END = StVsample;
`else
    localparam state_e WBEAT_END = StHold;
`endif

    state_e            state;
    logic              op;
    logic [2:0]        setup_cnt;
    logic              setup_done;
    logic              gen_load;
    logic              gen_step;
    logic [ADDR_W-1:0] addr;
    logic              last;

    assign req_ready  = (state == StIdle);
    assign w_ready    = (state == StWdata);
    assign setup_done = (setup_cnt == SETUP_LAST);

    // The generator steps while the current address is no longer needed on the bus:
    // mem_address is a separate register that only reloads on entry to SETUP.
    always_comb begin
        gen_load = (state == StIdle) && req_valid;
        gen_step = 1'b0;
        if (!last && ((state == StSample) || (state == WBEAT_END))) begin
            gen_step = 1'b1;
        end
    end

    mem_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (gen_load),
        .step       (gen_step),
        .start_addr (req_addr),
        .len        (req_len),
        .addr       (addr),
        .last       (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            op          <= OP_READ;
            setup_cnt   <= '0;
            mem_address <= '0;
            mem_data_in <= '0;
            mem_write   <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_last      <= 1'b0;
            done        <= 1'b0;
`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
            verify_err  <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        op <= req_write;
`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
                        verify_err <= 1'b0;
`endif
                        if (req_write == OP_WRITE) begin
                            state <= StWdata;
                        end else begin
                            mem_address <= req_addr;
                            state       <= StSetup;
                        end
                    end
                end
                StWdata: begin
                    if (w_valid) begin
                        mem_data_in <= w_data;
                        mem_address <= addr;
                        state       <= StSetup;
                    end
                end
                StSetup: begin
                    if (setup_done) begin
                        setup_cnt <= '0;
                        if (op == OP_WRITE) begin
                            mem_write <= 1'b1;
                            state     <= StStrobe;
                        end else begin
                            state <= StSample;
                        end
                    end else begin
                        setup_cnt <= setup_cnt + 1'b1;
                    end
                end
                StStrobe: state <= StHold;
                StHold: begin
`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
                    state <= StVsetup;
`else
                    if (last) begin
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        state <= StWdata;
                    end
`endif
                end
`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
                StVsetup: begin
                    if (setup_done) begin
                        setup_cnt <= '0;
                        state     <= StVsample;
                    end else begin
                        setup_cnt <= setup_cnt + 1'b1;
                    end
                end
                StVsample: begin
                    if (mem_data_out != mem_data_in) begin
                        verify_err <= 1'b1;
                    end
                    if (last) begin
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        state <= StWdata;
                    end
                end
`endif
                StSample: begin
                    r_data  <= mem_data_out;
                    r_valid <= 1'b1;
                    r_last  <= last;
                    state   <= StRvalid;
                end
                StRvalid: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (r_last) begin
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            mem_address <= addr;
                            state       <= StSetup;
                        end
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: directed self-checking bench for mem_initiator with a behavioural
// 32x8 asynchronous memory model (combinational read, write while mem_write is high).
// Build option: MEM_INITIATOR_WRITE_VERIFY_EN adds the stuck-bit verify scenario.
module tb_mem_initiator;
    import mem_initiator_pkg::*;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [2:0]    req_len = '0;
    logic          w_valid = 1'b0;
    logic          w_ready;
    logic [DW-1:0] w_data = '0;
    logic          r_valid;
    logic          r_ready = 1'b0;
    logic [DW-1:0] r_data;
    logic          r_last;
    logic          done;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic          mem_write;
    logic [DW-1:0] mem_data_out;
`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
    logic          verify_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_initiator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .r_valid      (r_valid),
        .r_ready      (r_ready),
        .r_data       (r_data),
        .r_last       (r_last),
        .done         (done),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
        .verify_err   (verify_err),
`endif
        .mem_data_out (mem_data_out)
    );

    // Memory model
    logic [7:0] mem [32];
    logic       preload = 1'b0;
    logic [7:0] rd_mask = 8'hFF;

    function automatic logic [7:0] init_val(input int i);
        case (i)
            0:       return 8'd0;
            5:       return 8'd18;
            6:       return 8'd110;
            7:       return 8'h82;
            8:       return 8'd53;
            30:      return 8'd114;
            31:      return 8'd11;
            default: return 8'(i * 7 + 3);
        endcase
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
        end else if (mem_write) begin
            mem[mem_address] <= mem_data_in;
        end
    end

    assign mem_data_out = mem[mem_address] & rd_mask;

    // Strobe monitor: mem_write one cycle wide, address steady around it.
    logic          mw_prev = 1'b0;
    logic [AW-1:0] addr_prev = '0;
    int            strobe_viol = 0;
    int            strobe_cnt = 0;

    always @(negedge clk) begin
        mw_prev   <= mem_write;
        addr_prev <= mem_address;
        if (rst_n && (mem_write || mw_prev) &&
            ((mem_address != addr_prev) || (mem_write && mw_prev))) begin
            strobe_viol <= strobe_viol + 1;
        end
        if (mem_write) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] rb_data [8];
    logic       rb_last [8];
    int         rb_cyc  [8];
    int         rb_beats;
    int         rb_holds;
    int         rb_stab_err;

    // Read burst; rpat=0 keeps r_ready high, otherwise r_ready is high 1 cycle in rpat.
    task automatic read_burst(input logic [4:0] addr, input logic [2:0] len, input int rpat);
        int         cyc = 0;
        logic       held = 1'b0;
        logic [7:0] prev = '0;
        rb_beats = 0;
        rb_holds = 0;
        rb_stab_err = 0;
        req_valid = 1'b1;
        req_write = OP_READ;
        req_addr  = addr;
        req_len   = len;
        @(negedge clk);
        req_valid = 1'b0;
        while (rb_beats <= int'(len) && cyc < 100) begin
            r_ready = (rpat == 0) ? 1'b1 : ((cyc % rpat) == 0);
            if (r_valid) begin
                if (held && (r_data != prev)) rb_stab_err++;
                if (r_ready) begin
                    rb_data[3'(rb_beats)] = r_data;
                    rb_last[3'(rb_beats)] = r_last;
                    rb_cyc[3'(rb_beats)]  = cyc;
                    rb_beats++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    prev = r_data;
                    rb_holds++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        r_ready = 1'b0;
        check_eq("rd_beats", rb_beats, int'(len) + 1);
        check_eq("rd_done_pulse", 32'(done), 1);
        @(negedge clk);
        check_eq("rd_done_clear", 32'(done), 0);
        check_eq("rd_idle_ready", 32'(req_ready), 1);
        check_eq("rd_no_extra_beat", 32'(r_valid), 0);
    endtask

    int wb_stalls;

    // Write burst; each beat's w_valid is withheld for 'delay' cycles of w_ready.
    task automatic write_burst(input logic [4:0] addr, input logic [2:0] len,
                               input logic [63:0] bytes, input int delay, input logic poke);
        int   cyc = 0;
        int   beat = 0;
        int   waited = 0;
        int   s0 = strobe_cnt;
        logic seen = 1'b0;
        wb_stalls = 0;
        req_valid = 1'b1;
        req_write = OP_WRITE;
        req_addr  = addr;
        req_len   = len;
        @(negedge clk);
        req_valid = 1'b0;
        while (!seen && cyc < 200) begin
            if (w_valid) begin
                w_valid = 1'b0;
                beat++;
                waited = 0;
            end
            if (w_ready) begin
                if (waited >= delay) begin
                    w_valid = 1'b1;
                    w_data  = 8'(bytes >> (8 * beat));
                end else begin
                    waited++;
                    wb_stalls++;
                end
            end
            if (poke && cyc == 3) begin
                req_valid = 1'b1;
                req_write = OP_READ;
                req_addr  = '0;
                req_len   = '0;
                check_eq("busy_req_ready", 32'(req_ready), 0);
            end
            if (cyc == 4) req_valid = 1'b0;
            if (done) seen = 1'b1;
            if (!seen) begin
                @(negedge clk);
                cyc++;
            end
        end
        w_valid = 1'b0;
        check_eq("wr_done_seen", 32'(seen), 1);
        check_eq("wr_beats", beat, int'(len) + 1);
        check_eq("wr_strobes", strobe_cnt - s0, int'(len) + 1);
        @(negedge clk);
        check_eq("wr_done_clear", 32'(done), 0);
        check_eq("wr_idle_ready", 32'(req_ready), 1);
    endtask

    initial begin
        int cyc;
        preload = 1'b1;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        preload = 1'b0;

        // Reset state
        check_eq("rst_mem_write", 32'(mem_write), 0);
        check_eq("rst_mem_address", 32'(mem_address), 0);
        check_eq("rst_mem_data_in", 32'(mem_data_in), 0);
        check_eq("rst_r_valid", 32'(r_valid), 0);
        check_eq("rst_r_data", 32'(r_data), 0);
        check_eq("rst_r_last", 32'(r_last), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_w_ready", 32'(w_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 1);

        // Read burst wrapping past the top of memory
        read_burst(5'd30, 3'd2, 0);
        check_eq("wrap_beat0", 32'(rb_data[0]), 114);
        check_eq("wrap_beat1", 32'(rb_data[1]), 11);
        check_eq("wrap_beat2", 32'(rb_data[2]), 0);
        check_eq("wrap_last0", 32'(rb_last[0]), 0);
        check_eq("wrap_last1", 32'(rb_last[1]), 0);
        check_eq("wrap_last2", 32'(rb_last[2]), 1);
        check_eq("read_beat_cycles", rb_cyc[1] - rb_cyc[0], 3);

        // Single write then readback
        write_burst(5'd1, 3'd0, 64'h08, 0, 1'b0);
        check_eq("wr_no_stall", wb_stalls, 0);
        read_burst(5'd1, 3'd0, 0);
        check_eq("wr1_readback", 32'(rb_data[0]), 8);

        // Read with backpressure
        read_burst(5'd5, 3'd3, 3);
        check_eq("bp_beat0", 32'(rb_data[0]), 18);
        check_eq("bp_beat1", 32'(rb_data[1]), 110);
        check_eq("bp_beat2", 32'(rb_data[2]), 'h82);
        check_eq("bp_beat3", 32'(rb_data[3]), 53);
        check_eq("bp_last3", 32'(rb_last[3]), 1);
        check_eq("bp_held_stable", rb_stab_err, 0);
        check_eq("bp_some_hold", 32'(rb_holds > 0), 1);

        // Write burst with slow write data and a request poked mid-burst
        write_burst(5'd20, 3'd1, 64'h3CA5, 4, 1'b1);
        check_eq("wdata_stall_cycles", wb_stalls, 8);
        read_burst(5'd20, 3'd1, 0);
        check_eq("slow_wr_mem20", 32'(rb_data[0]), 'hA5);
        check_eq("slow_wr_mem21", 32'(rb_data[1]), 'h3C);

        // Reset asserted during STROBE
        req_valid = 1'b1;
        req_write = OP_WRITE;
        req_addr  = 5'd3;
        req_len   = 3'd0;
        @(negedge clk);
        req_valid = 1'b0;
        w_valid   = 1'b1;
        w_data    = 8'h5A;
        cyc = 0;
        while (!mem_write && cyc < 20) begin
            @(negedge clk);
            w_valid = 1'b0;
            cyc++;
        end
        check_eq("rst_strobe_reached", 32'(mem_write), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_mem_write", 32'(mem_write), 0);
        check_eq("midrst_r_valid", 32'(r_valid), 0);
        check_eq("midrst_done", 32'(done), 0);
        check_eq("midrst_mem_address", 32'(mem_address), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_req_ready", 32'(req_ready), 1);
        read_burst(5'd0, 3'd0, 0);
        check_eq("midrst_read0", 32'(rb_data[0]), 0);
        read_burst(5'd3, 3'd0, 0);
        check_eq("midrst_mem3_untouched", 32'(rb_data[0]), 24);

`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
        // Bit 0 stuck low in the memory read path
        rd_mask = 8'hFE;
        write_burst(5'd10, 3'd0, 64'h01, 0, 1'b0);
        check_eq("verify_err_set", 32'(verify_err), 1);
        repeat (3) @(negedge clk);
        check_eq("verify_err_sticky", 32'(verify_err), 1);
        write_burst(5'd11, 3'd0, 64'h02, 0, 1'b0);
        check_eq("verify_err_clean", 32'(verify_err), 0);
        rd_mask = 8'hFF;
`endif

        check_eq("strobe_protocol", strobe_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Bus-side initiator for the 32x8 asynchronous data memory: the CPU-side master that drives `address`/`data_in`/`write` and samples `data_out`.
- Accepts burst read/write requests from the core over valid/ready handshakes.
- Sequences address setup, write strobe and hold so the level-sensitive memory never sees a write while the address is changing.
- Streams read data back with backpressure.

Parameters:
- ADDR_W, 5, memory address width (depth 2**ADDR_W, wraps modulo depth)
- DATA_W, 8, memory word width
- SETUP_CYC, 1, cycles (1..7) address is held stable before a strobe or sample

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_write  in  1  1=write burst, 0=read burst
- req_addr  in  ADDR_W  start address
- req_len  in  3  beats minus one (0..7 -> 1..8 beats)
- w_valid  in  1  write beat data present
- w_ready  out  1  write data accepted this cycle
- w_data  in  DATA_W  write beat data
- r_valid  out  1  read beat data valid
- r_ready  in  1  consumer accepts read beat
- r_data  out  DATA_W  read beat data
- r_last  out  1  marks final read beat
- done  out  1  one-cycle pulse at burst completion
- mem_address  out  ADDR_W  to memory address
- mem_data_in  out  DATA_W  to memory data_in
- mem_write  out  1  to memory write
- mem_data_out  in  DATA_W  from memory data_out

Behaviour:
- Reset (async, rst_n=0): state IDLE. mem_write=0, mem_address=0, mem_data_in=0, r_valid=0, r_data=0, r_last=0, done=0, w_ready=0. req_ready=1 after release.
- All outputs are registered except req_ready and w_ready, which decode state combinationally.
- States: IDLE, WDATA, SETUP, STROBE, HOLD, SAMPLE, RVALID, DONE.
- IDLE:
  - Handshake when req_valid & req_ready: latch addr, len, op.
  - Load beat counter = req_len.
  - Next state WDATA for writes, SETUP for reads.
- WDATA:
  - w_ready=1.
  - On w_valid, latch w_data into mem_data_in and go to SETUP.
  - Stall indefinitely without w_valid.
- SETUP:
  - mem_address = current addr, mem_write=0.
  - Stay SETUP_CYC cycles, then STROBE (write) or SAMPLE (read).
- STROBE: mem_write=1 for exactly one cycle -> HOLD.
- HOLD:
  - mem_write=0; address and data unchanged.
  - If counter==0 -> DONE, else decrement, addr+1, -> WDATA.
- SAMPLE:
  - Register mem_data_out into r_data.
  - r_valid=1; r_last=1 iff counter==0.
  - -> RVALID.
- RVALID:
  - Hold r_valid/r_data/r_last until r_ready.
  - On r_ready: r_valid=0. If last -> DONE, else decrement, addr+1, -> SETUP.
- DONE: done=1 one cycle -> IDLE.
- Address increment wraps 2**ADDR_W-1 -> 0.
- mem_write is never high in the same cycle mem_address changes; address changes only on entry to SETUP.
- Minimum read beat latency (SETUP_CYC=1, r_ready tied high): SETUP, SAMPLE, RVALID = 3 cycles/beat. Write beat with w_valid high: WDATA, SETUP, STROBE, HOLD = 4 cycles/beat.
- req_valid while busy: ignored (req_ready=0); the request is not queued.
- Reset mid-burst: immediate return to IDLE, mem_write drops asynchronously, partial burst abandoned, no done pulse.

Optional Feature:
- Macro MEM_INITIATOR_WRITE_VERIFY_EN.
- When defined:
  - After each HOLD, insert VSETUP (SETUP_CYC cycles, mem_write=0) and VSAMPLE, comparing mem_data_out to the written data.
  - Mismatch sets extra output port verify_err (1 bit, sticky until next accepted request, reset 0).
  - Adds 1+SETUP_CYC cycles per write beat.
- When undefined: no verify states, verify_err port absent, timing as above.

Decomposition:
- Package mem_initiator_pkg:
  - state enum
  - OP_READ/OP_WRITE constants
  - LEN_W=3
  - default ADDR_W/DATA_W constants shared with the memory.
- One sub-module, mem_addr_gen:
  - Holds current address and beat counter.
  - Inputs: load, step, start address, length.
  - Outputs: addr, last flag.
  - Wraps modulo depth.

Test Plan:
- Read burst addr=30 len=2, r_ready=1 -> r_data sequence 114, 11, 0 (wrap); r_last on third beat; done one cycle after last handshake.
- Write addr=1 len=0 w_data=8, then read addr=1 len=0 -> r_data=8; mem_write high exactly one cycle with mem_address=1 stable in the cycles before and after.
- Read addr=5 len=3 with r_ready toggling 1 cycle in 3 -> beats 18, 110, -126 (0x82), 53 each held stable until accepted; no beat lost or duplicated.
- Write burst addr=20 len=1 with w_valid delayed 4 cycles per beat -> FSM stalls in WDATA; mem[20]=w0, mem[21]=w1 confirmed by readback; req_valid pulsed mid-burst ignored.
- Assert rst_n=0 during STROBE of a write burst -> mem_write, r_valid, done fall immediately; after release req_ready=1 and a new read of addr=0 returns 0.
- With MEM_INITIATOR_WRITE_VERIFY_EN, model memory forces bit0 stuck at 0, write 0x01 -> verify_err=1 and sticky until the next accepted request; write 0x02 -> verify_err stays 0.
